// File: rtl/cpu_rom_checksum.sv
// Walks six 4 KiB program ROMs one byte at a time and reports a modulo-256 checksum per ROM.
// The bus sequence for each byte is ADDR (enable low), RD (read strobe low), then ACC.
module cpu_rom_checksum #(
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST_AL,
  input  logic       START,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  output logic       A5,
  output logic       A6,
  output logic       A7,
  output logic       A8,
  output logic       A9,
  output logic       A10,
  output logic       A11,
  output logic       ROM0_AL,
  output logic       ROM1_AL,
  output logic       ROM2_AL,
  output logic       ROM3_AL,
  output logic       ROM4_AL,
  output logic       ROM5_AL,
  output logic       MR_AL,
  output logic       BUSY,
  output logic       SUM_VALID,
  output logic [2:0] SUM_IDX,
  output logic [7:0] SUM,
  output logic       DONE
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAddr   = 3'd1;
  localparam logic [2:0] StRd     = 3'd2;
  localparam logic [2:0] StAcc    = 3'd3;
  localparam logic [2:0] StReport = 3'd4;
  localparam logic [2:0] StFin    = 3'd5;

  localparam logic [3:0] RdLast = 4'(ACCESS_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  byte_q, byte_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [2:0]  sum_idx_q, sum_idx_d;
  logic [7:0]  din;
  logic [5:0]  en_n;
  logic        sel;

  assign din = {D7, D6, D5, D4, D3, D2, D1, D0};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    byte_d    = byte_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    sum_idx_d = sum_idx_q;
    case (state_q)
      StIdle: begin
        if (START) begin
          addr_d  = 12'h000;
          idx_d   = 3'd0;
          acc_d   = 8'h00;
          state_d = StAddr;
        end
      end
      StAddr: begin
        cnt_d   = 4'd0;
        state_d = StRd;
      end
      StRd: begin
        // The byte is captured on the edge that closes the final strobe cycle.
        if (cnt_q == RdLast) begin
          byte_d  = din;
          state_d = StAcc;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StAcc: begin
        acc_d = acc_q + byte_q;
        if (addr_q == 12'hFFF) begin
          sum_d     = acc_q + byte_q;
          sum_idx_d = idx_q;
          state_d   = StReport;
        end else begin
          addr_d  = addr_q + 12'd1;
          state_d = StAddr;
        end
      end
      StReport: begin
        acc_d  = 8'h00;
        addr_d = 12'h000;
        if (idx_q == 3'd5) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StAddr;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_AL) begin
      state_q   <= StIdle;
      addr_q    <= 12'h000;
      idx_q     <= 3'd0;
      acc_q     <= 8'h00;
      byte_q    <= 8'h00;
      cnt_q     <= 4'd0;
      sum_q     <= 8'h00;
      sum_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sum_idx_q <= sum_idx_d;
    end
  end

  // Chip enable spans ADDR and RD only, so the address may move during ACC.
  assign sel = (state_q == StAddr) || (state_q == StRd);

  always_comb begin
    en_n = 6'h3F;
    for (int i = 0; i < 6; i++) begin
      en_n[i] = !(sel && (idx_q == 3'(i)));
    end
  end

  assign {A11, A10, A9, A8, A7, A6, A5, A4, A3, A2, A1, A0} = addr_q;
  assign {ROM5_AL, ROM4_AL, ROM3_AL, ROM2_AL, ROM1_AL, ROM0_AL} = en_n;

  assign MR_AL     = (state_q != StRd);
  assign BUSY      = (state_q != StIdle);
  assign SUM_VALID = (state_q == StReport);
  assign DONE      = (state_q == StFin);
  assign SUM       = sum_q;
  assign SUM_IDX   = sum_idx_q;

endmodule

// File: tb/tb_cpu_rom_checksum.sv
// Bench for cpu_rom_checksum: two instances (ACCESS_CYCLES=1 and default 3) share one ROM image;
// a scoreboard holds per-ROM sums from a reference model and a monitor checks reports and bus timing.
module tb_cpu_rom_checksum;

  localparam logic [32:0] RST_OBS = {12'h000, 6'h3F, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst1, rst3, start1, start3;
  logic [7:0]  d1, d3;
  logic [11:0] a1, a3;
  logic [5:0]  en1, en3;
  logic        mr1, mr3, busy1, busy3, sv1, sv3, done1, done3;
  logic [2:0]  idx1, idx3;
  logic [7:0]  sum1, sum3;

  logic [7:0]  rom [6][4096];
  logic [32:0] obs [2];

  int          checks = 0;
  int          failures = 0;
  logic [10:0] exp1_q[$];
  logic [10:0] exp3_q[$];
  int          en_run [2];
  int          mr_run [2];
  logic [11:0] prev_a [2];
  logic        prev_mr [2];
  logic        prev_busy [2];
  int unsigned start_cyc [2];
  int          done_cnt [2];
  logic [7:0]  last_sum [2];
  logic [2:0]  last_idx [2];

  function automatic logic [5:0] en_for(input int r);
    return ~(6'd1 << r);
  endfunction

  // Behavioural ROM: drives data only while its output enable and exactly one chip enable are low.
  always_comb begin
    d1 = 8'hA5;
    d3 = 8'hA5;
    for (int r = 0; r < 6; r++) begin
      if (!mr1 && en1 == en_for(r)) d1 = rom[r][a1];
      if (!mr3 && en3 == en_for(r)) d3 = rom[r][a3];
    end
  end

  always_comb begin
    obs[0] = {a1, en1, mr1, busy1, sv1, idx1, sum1, done1};
    obs[1] = {a3, en3, mr3, busy3, sv3, idx3, sum3, done3};
  end

  cpu_rom_checksum #(.ACCESS_CYCLES(1)) u1 (
    .CLK(clk), .RST_AL(rst1), .START(start1),
    .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]),
    .D4(d1[4]), .D5(d1[5]), .D6(d1[6]), .D7(d1[7]),
    .A0(a1[0]), .A1(a1[1]), .A2(a1[2]), .A3(a1[3]), .A4(a1[4]), .A5(a1[5]),
    .A6(a1[6]), .A7(a1[7]), .A8(a1[8]), .A9(a1[9]), .A10(a1[10]), .A11(a1[11]),
    .ROM0_AL(en1[0]), .ROM1_AL(en1[1]), .ROM2_AL(en1[2]),
    .ROM3_AL(en1[3]), .ROM4_AL(en1[4]), .ROM5_AL(en1[5]),
    .MR_AL(mr1), .BUSY(busy1), .SUM_VALID(sv1), .SUM_IDX(idx1), .SUM(sum1), .DONE(done1)
  );

  cpu_rom_checksum u3 (
    .CLK(clk), .RST_AL(rst3), .START(start3),
    .D0(d3[0]), .D1(d3[1]), .D2(d3[2]), .D3(d3[3]),
    .D4(d3[4]), .D5(d3[5]), .D6(d3[6]), .D7(d3[7]),
    .A0(a3[0]), .A1(a3[1]), .A2(a3[2]), .A3(a3[3]), .A4(a3[4]), .A5(a3[5]),
    .A6(a3[6]), .A7(a3[7]), .A8(a3[8]), .A9(a3[9]), .A10(a3[10]), .A11(a3[11]),
    .ROM0_AL(en3[0]), .ROM1_AL(en3[1]), .ROM2_AL(en3[2]),
    .ROM3_AL(en3[3]), .ROM4_AL(en3[4]), .ROM5_AL(en3[5]),
    .MR_AL(mr3), .BUSY(busy3), .SUM_VALID(sv3), .SUM_IDX(idx3), .SUM(sum3), .DONE(done3)
  );

  function automatic int ac_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int unsigned pass_len(input int ac);
    return 6 * (4096 * (ac + 2) + 1) + 1;
  endfunction

  function automatic logic [7:0] model_sum(input int r);
    int s;
    s = 0;
    for (int i = 0; i < 4096; i++) s += int'(rom[r][i]);
    return 8'(s % 256);
  endfunction

  task automatic chk(input string name, input int k, input logic [32:0] got,
                     input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s (ACCESS_CYCLES=%0d) got=%0h expected=%0h", name, ac_of(k), got, exp);
    end
  endtask

  task automatic monitor_step(input int k);
    logic [32:0] o;
    logic [11:0] a;
    logic [5:0]  en;
    logic        mr, busy, sv, done;
    logic [2:0]  idx;
    logic [7:0]  sum;
    logic [10:0] e;
    logic        empty;
    int          nlow;
    o = obs[k];
    a = o[32:21]; en = o[20:15]; mr = o[14]; busy = o[13]; sv = o[12];
    idx = o[11:9]; sum = o[8:1]; done = o[0];
    nlow = 0;
    for (int i = 0; i < 6; i++) if (!en[i]) nlow++;
    chk("multiple_enables_low", k, 33'(nlow > 1), 33'd0);
    if (!mr) chk("mr_without_single_enable", k, 33'(nlow), 33'd1);
    if (!mr && !prev_mr[k]) chk("addr_stable_while_mr_low", k, 33'(a), 33'(prev_a[k]));
    if (nlow != 0) begin
      en_run[k]++;
      if (!mr) mr_run[k]++;
      if (en_run[k] == 1) chk("mr_high_in_addr_cycle", k, 33'(mr), 33'd1);
    end else if (en_run[k] != 0) begin
      chk("enable_low_cycles", k, 33'(en_run[k]), 33'(ac_of(k) + 1));
      chk("mr_low_cycles", k, 33'(mr_run[k]), 33'(ac_of(k)));
      en_run[k] = 0;
      mr_run[k] = 0;
    end
    if (busy && !prev_busy[k]) start_cyc[k] = cyc;
    if (sv) begin
      empty = 1'b0;
      e = '0;
      if (k == 0) begin
        if (exp1_q.size() == 0) empty = 1'b1; else e = exp1_q.pop_front();
      end else begin
        if (exp3_q.size() == 0) empty = 1'b1; else e = exp3_q.pop_front();
      end
      if (empty) begin
        checks++;
        failures++;
        $display("FAIL unexpected_report (ACCESS_CYCLES=%0d) got idx=%0d sum=%02h expected none",
                 ac_of(k), idx, sum);
      end else begin
        chk("report_idx_sum", k, 33'({idx, sum}), 33'(e));
        last_idx[k] = e[10:8];
        last_sum[k] = e[7:0];
      end
    end else begin
      chk("sum_hold", k, 33'({idx, sum}), 33'({last_idx[k], last_sum[k]}));
    end
    if (done) begin
      done_cnt[k]++;
      chk("pass_length", k, 33'(cyc - start_cyc[k] + 1), 33'(pass_len(ac_of(k))));
    end
    prev_a[k]    = a;
    prev_mr[k]   = mr;
    prev_busy[k] = busy;
  endtask

  initial begin
    logic found, got;
    int   n;
    rst1 = 1'b0; rst3 = 1'b0; start1 = 1'b0; start3 = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4096; i++) begin
        if (r < 4) rom[r][i] = 8'($urandom_range(0, 255));
        else if (r == 4) rom[r][i] = 8'h01;
        else rom[r][i] = 8'h00;
      end
    end
    rom[2][12'h7FF] = 8'h3C;
    rom[5][12'h000] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      en_run[k] = 0; mr_run[k] = 0; prev_a[k] = '0; prev_mr[k] = 1'b1; prev_busy[k] = 1'b0;
      start_cyc[k] = 0; done_cnt[k] = 0; last_sum[k] = '0; last_idx[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b1; rst3 = 1'b1;
    fork
      forever begin
        @(negedge clk);
        monitor_step(0);
        monitor_step(1);
      end
    join_none

    repeat (10) begin
      @(negedge clk);
      chk("reset_idle_outputs", 0, obs[0], RST_OBS);
      chk("reset_idle_outputs", 1, obs[1], RST_OBS);
    end

    for (int r = 0; r < 6; r++) begin
      exp1_q.push_back({3'(r), model_sum(r)});
      exp3_q.push_back({3'(r), model_sum(r)});
    end
    @(posedge clk); #1 start1 = 1'b1;
    // The default-timing instance gets one real start, then random START noise for the whole run.
    fork
      begin
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        forever begin
          @(posedge clk); #1 start3 = ($urandom_range(0, 31) == 0);
        end
      end
    join_none
    @(posedge clk); #1 start1 = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!mr1 && en1 == 6'b111101 && a1 == 12'h100) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_point_reached", 0, 33'(found), 33'd1);
    rst1 = 1'b0;
    @(posedge clk); #1 rst1 = 1'b1;
    last_sum[0] = 8'h00;
    last_idx[0] = 3'd0;
    @(negedge clk);
    chk("reset_after_abort", 0, obs[0], RST_OBS);
    chk("reports_before_abort", 0, 33'(exp1_q.size()), 33'd5);
    exp1_q.delete();
    repeat (3) @(negedge clk);

    @(posedge clk); #1;
    for (int r = 0; r < 6; r++) exp1_q.push_back({3'(r), model_sum(r)});
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("restart_rom0_addr0", 0, 33'({busy1, mr1, en1, a1}), 33'({1'b1, 1'b1, 6'b111110, 12'h000}));

    got = 1'b0;
    for (int i = 0; i < 80000; i++) begin
      @(posedge clk); #1;
      if (i < 70000) start1 = ($urandom_range(0, 15) == 0);
      else start1 = (i >= 72000);
      @(negedge clk);
      if (done1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 0, 33'(got), 33'd1);
    @(negedge clk);
    chk("idle_after_fin", 0, 33'({busy1, en1, mr1}), 33'({1'b0, 6'h3F, 1'b1}));
    @(negedge clk);
    chk("held_start_restarts", 0, 33'({busy1, mr1, en1, a1}), 33'({1'b1, 1'b1, 6'b111110, 12'h000}));
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); #1;

    chk("done_count", 0, 33'(done_cnt[0]), 33'd1);
    chk("all_reports_seen", 0, 33'(exp1_q.size()), 33'd0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (start_cyc[1] + 32'((k + 1) * (4096 * 5 + 1)) - 1 < cyc) n++;
    end
    chk("reports_so_far", 1, 33'(6 - exp3_q.size()), 33'(n));
    chk("done_count", 1, 33'(done_cnt[1]), 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
